// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : tiny8 instruction fetch stage. It owns the PC, assembles 1/2-byte
//            instructions into a one-entry buffer and handles redirects.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] mem_addr,
    output logic       mem_read,
    input  logic [7:0] mem_rdata,
    input  logic       mem_resp,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_imm,
    output logic [7:0] instr_pc,
    input  logic       redirect,
    input  logic [7:0] redirect_pc
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_FETCH_OP  = 3'd1;
    localparam logic [2:0] c_FETCH_IMM = 3'd2;
    localparam logic [2:0] c_HOLD      = 3'd3;
    localparam logic [2:0] c_DRAIN     = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_pc;
    logic [7:0] r_pc_pending;
    logic [7:0] r_opcode;
    logic [7:0] r_imm;
    logic [7:0] r_instr_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: w_state_nxt = c_FETCH_OP;
            c_FETCH_OP: begin
                if (mem_resp) begin
                    if (redirect)          w_state_nxt = c_FETCH_OP;
                    else if (mem_rdata[7]) w_state_nxt = c_FETCH_IMM;
                    else                   w_state_nxt = c_HOLD;
                end else if (redirect) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_FETCH_IMM: begin
                if (mem_resp)      w_state_nxt = redirect ? c_FETCH_OP : c_HOLD;
                else if (redirect) w_state_nxt = c_DRAIN;
            end
            c_HOLD: begin
                if (redirect || instr_ready) w_state_nxt = c_FETCH_OP;
            end
            c_DRAIN: begin
                if (mem_resp) w_state_nxt = c_FETCH_OP;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        mem_read    = (r_state == c_FETCH_OP) || (r_state == c_FETCH_IMM) ||
                      (r_state == c_DRAIN);
        instr_valid = (r_state == c_HOLD);
        mem_addr    = r_pc;
    end

    // A redirect that coincides with a response wins over the response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_pc_pending <= 8'h00;
            r_opcode     <= 8'h00;
            r_imm        <= 8'h00;
            r_instr_pc   <= 8'h00;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (redirect) r_pc <= redirect_pc;
                end
                c_FETCH_OP: begin
                    if (mem_resp) begin
                        if (redirect) begin
                            r_pc <= redirect_pc;
                        end else begin
                            r_opcode   <= mem_rdata;
                            r_instr_pc <= r_pc;
                            r_pc       <= r_pc + 8'd1;
                            if (!mem_rdata[7]) r_imm <= 8'h00;
                        end
                    end else if (redirect) begin
                        r_pc_pending <= redirect_pc;
                    end
                end
                c_FETCH_IMM: begin
                    if (mem_resp) begin
                        if (redirect) begin
                            r_pc <= redirect_pc;
                        end else begin
                            r_imm <= mem_rdata;
                            r_pc  <= r_pc + 8'd1;
                        end
                    end else if (redirect) begin
                        r_pc_pending <= redirect_pc;
                    end
                end
                c_HOLD: begin
                    if (redirect) r_pc <= redirect_pc;
                end
                c_DRAIN: begin
                    // r_pc stays on the abandoned address until the read retires.
                    if (mem_resp)      r_pc <= redirect ? redirect_pc : r_pc_pending;
                    else if (redirect) r_pc_pending <= redirect_pc;
                end
                default: ;
            endcase
        end
    end

    assign instr_opcode = r_opcode;
    assign instr_imm    = r_imm;
    assign instr_pc     = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed and randomized bench for fetch_unit with a memory model
//            and an instruction-stream scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [7:0] c_reset_pc = 8'h10;

    typedef struct {
        logic [7:0] op;
        logic [7:0] imm;
        logic [7:0] pc;
        logic [7:0] next_pc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] mem_addr;
    logic       mem_read;
    logic [7:0] mem_rdata;
    logic       mem_resp;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_imm;
    logic [7:0] instr_pc;
    logic       redirect;
    logic [7:0] redirect_pc;

    logic [7:0] mem [256];
    int         force_wait;
    int         wait_cnt;
    bit         served;
    bit         noise;
    int         n_cmp;
    int         n_err;
    int         n_acc;
    exp_t       exp_q [$];

    fetch_unit #(.RESET_PC(c_reset_pc)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_imm    (instr_imm),
        .instr_pc     (instr_pc),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_wait();
        return (force_wait >= 0) ? force_wait : int'($urandom_range(3, 0));
    endfunction

    // Reference: the instruction that lives at address a in program memory.
    function automatic exp_t decode(input logic [7:0] a);
        exp_t       e;
        logic [7:0] a1;
        a1     = a + 8'd1;
        e.pc   = a;
        e.op   = mem[a];
        e.imm  = e.op[7] ? mem[a1] : 8'h00;
        e.next_pc = e.op[7] ? (a + 8'd2) : a1;
        return e;
    endfunction

    // Memory: responds after a per-request number of wait cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_resp  = 1'b0;
            mem_rdata = 8'h00;
            served    = 1'b0;
            wait_cnt  = pick_wait();
        end else begin
            if (served) wait_cnt = pick_wait();
            served = 1'b0;
            if (mem_read) begin
                if (wait_cnt == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mem[mem_addr];
                    served    = 1'b1;
                end else begin
                    mem_resp  = 1'b0;
                    mem_rdata = 8'($urandom);
                    wait_cnt--;
                end
            end else begin
                mem_resp  = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                mem_rdata = 8'($urandom);
            end
        end
    end

    // Scoreboard: the queue holds the next instruction control should receive.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            exp_q.delete();
            exp_q.push_back(decode(c_reset_pc));
        end else begin
            if (instr_valid && instr_ready) begin
                n_acc++;
                chk("sb_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_opcode", instr_opcode, e.op);
                    chk("sb_imm", instr_imm, e.imm);
                    chk("sb_pc", instr_pc, e.pc);
                    exp_q.push_back(decode(e.next_pc));
                end
            end
            if (redirect) begin
                exp_q.delete();
                exp_q.push_back(decode(redirect_pc));
            end
        end
    end

    task automatic do_redirect(input logic [7:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_acc = 0;
        force_wait = 0; noise = 1'b0;
        rst_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(127, 0));
        mem[8'h10] = 8'h05; mem[8'h11] = 8'h06; mem[8'h12] = 8'hC3;
        mem[8'h20] = 8'h83; mem[8'h21] = 8'h7A; mem[8'h22] = 8'h01;
        mem[8'hFF] = 8'h81; mem[8'h00] = 8'h44; mem[8'h01] = 8'h02;
        mem[8'h40] = 8'h11; mem[8'h60] = 8'h22; mem[8'h70] = 8'h2A;

        step(); step();
        chk("rst_mem_read", mem_read, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_addr", mem_addr, c_reset_pc);
        chk("rst_regs", {instr_opcode, instr_imm, instr_pc}, 0);
        rst_n = 1'b1;
        chk("idle_no_read", mem_read, 0);
        step();
        chk("first_read", mem_read, 1);
        chk("first_addr", mem_addr, 8'h10);
        step();
        chk("one_byte_valid", instr_valid, 1);
        chk("one_byte_instr", {instr_opcode, instr_imm, instr_pc}, 24'h050010);
        step();
        chk("next_fetch_11", {mem_read, mem_addr}, 9'h111);

        // Two-byte instruction.
        do_redirect(8'h20);
        chk("redir_addr_20", {mem_read, mem_addr}, 9'h120);
        step();
        chk("imm_fetch_21", {instr_valid, mem_addr}, 9'h021);
        step();
        chk("two_byte_instr", {instr_valid, instr_opcode, instr_imm, instr_pc}, 25'h1837A20);
        step();
        chk("next_fetch_22", mem_addr, 8'h22);

        // Two-byte instruction wrapping the PC, then a 5-cycle stall.
        do_redirect(8'hFF);
        step();
        chk("wrap_imm_addr", mem_addr, 8'h00);
        step();
        instr_ready = 1'b0;
        chk("wrap_instr", {instr_valid, instr_opcode, instr_imm, instr_pc}, 25'h18144FF);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_stable", {mem_read, instr_valid, instr_opcode, instr_imm, instr_pc},
                26'h18144FF);
        end
        instr_ready = 1'b1;
        step();
        chk("resume_fetch_01", {mem_read, mem_addr}, 9'h101);

        // Redirect while a slow read is outstanding.
        force_wait = 3;
        do_redirect(8'h12);
        chk("slow_read_12", mem_addr, 8'h12);
        do_redirect(8'h40);
        force_wait = 0;
        begin : drain40
            int k;
            for (k = 0; k < 10 && mem_addr != 8'h40; k++) begin
                chk("drain_addr_12", {mem_read, mem_addr}, 9'h112);
                step();
            end
            chk("drain_bound_40", k < 10, 1);
        end
        chk("after_drain_40", {mem_read, mem_addr}, 9'h140);
        step();
        chk("instr_40", {instr_valid, instr_opcode, instr_pc}, 17'h11140);

        // Redirect in HOLD with ready, then two redirects around a drain.
        force_wait = 3;
        do_redirect(8'h60);
        chk("hold_redir_valid", instr_valid, 0);
        chk("hold_redir_addr", {mem_read, mem_addr}, 9'h160);
        do_redirect(8'h50);
        chk("drain_60", {mem_read, mem_addr}, 9'h160);
        force_wait = 0;
        do_redirect(8'h70);
        begin : drain70
            int k;
            for (k = 0; k < 10 && mem_addr != 8'h70; k++) begin
                chk("drain_addr_60", {mem_read, mem_addr}, 9'h160);
                step();
            end
            chk("drain_bound_70", k < 10, 1);
        end
        begin : wait70
            int k;
            for (k = 0; k < 10 && !instr_valid; k++) step();
            chk("valid_bound_70", k < 10, 1);
        end
        chk("instr_70", {instr_opcode, instr_pc}, 16'h2A70);
        step();

        // Randomized traffic.
        instr_ready = 1'b0;
        force_wait  = -1;
        noise       = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_redirect(8'($urandom));
        for (int c = 0; c < 4000; c++) begin
            instr_ready = ($urandom_range(99, 0) < 70);
            redirect    = ($urandom_range(15, 0) == 0);
            redirect_pc = 8'($urandom);
            step();
        end
        redirect    = 1'b0;
        instr_ready = 1'b1;
        repeat (10) step();
        chk("accepts_seen", n_acc > 200, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the tiny8 core, directly upstream of `control`. It owns the program counter and reads instruction bytes from memory over a request/response port. It assembles one- or two-byte instructions into a one-entry buffer and hands them to `control` with a valid/ready handshake. `control` redirects it on taken branches and jumps.

## Interface
- `RESET_PC`, default 8'h00: PC loaded on reset.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_addr`  out  8  byte address of the current fetch; always equals the internal PC.
- `mem_read`  out  1  read request; held until `mem_resp`.
- `mem_rdata`  in  8  read data, valid when `mem_resp`=1.
- `mem_resp`  in  1  read completion; ignored while `mem_read`=0.
- `instr_valid`  out  1  buffered instruction available.
- `instr_ready`  in  1  `control` accepts the buffered instruction.
- `instr_opcode`  out  8  opcode byte.
- `instr_imm`  out  8  immediate byte; 8'h00 for one-byte instructions.
- `instr_pc`  out  8  address of the opcode byte.
- `redirect`  in  1  single-cycle request to restart fetch at `redirect_pc`.
- `redirect_pc`  in  8  new fetch address.

## Operation
- States:
  - IDLE: post-reset only.
  - FETCH_OP: read opcode byte.
  - FETCH_IMM: read immediate byte.
  - HOLD: `instr_valid`=1, waiting for `instr_ready`.
  - DRAIN: discard an outstanding read after a redirect.
- `mem_read` = 1 exactly in FETCH_OP, FETCH_IMM and DRAIN.
- Reset values: state IDLE, PC = `RESET_PC`, pending-redirect flag 0, `instr_opcode`/`instr_imm`/`instr_pc` = 0. Outputs at reset: `mem_read`=0, `instr_valid`=0, `mem_addr`=`RESET_PC`.
- IDLE → FETCH_OP unconditionally on the first edge after reset release.
- FETCH_OP, on an edge with `mem_resp`=1:
  - Capture `mem_rdata` into `instr_opcode` and the PC into `instr_pc`, then PC+1.
  - If `mem_rdata[7]`=1 (two-byte instruction), go to FETCH_IMM.
  - Otherwise clear `instr_imm` and go to HOLD.
- FETCH_IMM, on an edge with `mem_resp`=1: capture `mem_rdata` into `instr_imm`, PC+1, go to HOLD.
- HOLD, on an edge with `instr_ready`=1: the instruction is consumed; go to FETCH_OP.
- Without `mem_resp` (FETCH_*) or `instr_ready` (HOLD), the state and all outputs hold.
- PC arithmetic is 8-bit modulo: 8'hFF + 1 = 8'h00. A two-byte instruction at 8'hFF takes its immediate from 8'h00.
- Redirect, sampled on the edge where `redirect`=1:
  - In FETCH_OP/FETCH_IMM with `mem_resp`=0: the read cannot be withdrawn. Latch `redirect_pc` into PC-pending and go to DRAIN.
  - In FETCH_OP/FETCH_IMM with `mem_resp`=1 on the same edge: discard the data, load PC = `redirect_pc`, go to FETCH_OP.
  - In HOLD: drop the buffered instruction, load PC = `redirect_pc`, go to FETCH_OP. If `instr_ready`=1 on the same edge, the handshake still counts as accepted by `control`; redirect governs the next fetch.
  - In DRAIN: overwrite PC-pending with the newer `redirect_pc`.
  - In IDLE: load PC and proceed to FETCH_OP.
- DRAIN: `mem_addr` keeps the address of the abandoned read. On `mem_resp`=1, discard the data, load PC = PC-pending, go to FETCH_OP.
- Discarded bytes never reach `instr_*` registers.
- An asynchronous reset mid-read returns to the reset values immediately. The memory is expected to be reset by the same `rst_n`.

## Timing
- `instr_*` outputs are registered. `mem_read`, `mem_addr` and `instr_valid` decode from registered state only, with no combinational path from any input.
- Zero-wait memory (`mem_resp` in the same cycle `mem_read` rises):
  - One-byte instruction: `instr_valid` asserts 1 cycle after entering FETCH_OP.
  - Two-byte instruction: `instr_valid` asserts 2 cycles after entering FETCH_OP.
- With `instr_ready` tied high and zero-wait memory:
  - One-byte instructions: one every 2 cycles.
  - Two-byte instructions: one every 3 cycles.
- First `mem_read` after reset: cycle 1 after release (the IDLE cycle is cycle 0).
- Each memory wait cycle adds exactly one cycle of latency.
- Redirect to first new `mem_read`:
  - 1 cycle when no read is outstanding.
  - Otherwise, 1 cycle after the draining `mem_resp`.

## Test plan
- Reset with `RESET_PC`=8'h10, zero-wait memory, `mem[10]`=8'h05, ready high → `mem_read` rises in cycle 1 at 8'h10; next edge `instr_valid`=1, opcode 8'h05, imm 8'h00, `instr_pc` 8'h10; next fetch at 8'h11.
- `mem[20]`=8'h83, `mem[21]`=8'h7A, fetch from 8'h20 → opcode 8'h83, imm 8'h7A, `instr_pc` 8'h20; next fetch at 8'h22.
- Two-byte opcode at 8'hFF, `mem[00]`=8'h44 → imm 8'h44; next fetch at 8'h01.
- `instr_ready` low for 5 cycles in HOLD → `instr_valid` and `instr_*` stable, `mem_read`=0; ready high for 1 cycle → fetch resumes at PC+1.
- Redirect to 8'h40 while a 3-wait-cycle read of 8'h12 is outstanding → `mem_addr` stays 8'h12 until `mem_resp`; that data never appears on `instr_*`; next read at 8'h40.
- Redirect to 8'h60 in HOLD with `instr_ready`=1 on the same edge → `instr_valid` drops next cycle and the next read is at 8'h60. Repeat with a second redirect to 8'h70 during DRAIN → the fetch goes to 8'h70.
